mmio_timer_slave: RTL and testbench



---
 rtl/mmio_timer_slave.sv | 181 ++++++++++++++++++
 tb/tb_mmio_timer_slave.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mmio_timer_slave.sv
// mmio_timer_slave: memory-mapped prescaled timer with compare match,
// one-shot / auto-reload modes and a level interrupt.
module mmio_timer_slave #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    PRESCALE_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] COMPARE_RST    = 32'hFFFF_FFFF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] wd,
    input  logic [31:0]           address,
    input  logic                  we,
    input  logic                  sel,
    output logic [DATA_WIDTH-1:0] rd,
    output logic                  irq
);

    localparam logic [2:0] IDX_CTRL     = 3'd0;
    localparam logic [2:0] IDX_PRESCALE = 3'd1;
    localparam logic [2:0] IDX_COMPARE  = 3'd2;
    localparam logic [2:0] IDX_COUNT    = 3'd3;
    localparam logic [2:0] IDX_STATUS   = 3'd4;

    localparam logic [PRESCALE_WIDTH-1:0] PONE = PRESCALE_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0]     CONE = DATA_WIDTH'(1);

    logic [2:0] idx;
    logic       wr;

    logic is_ctrl;
    logic is_prescale;
    logic is_compare;
    logic is_count;
    logic is_status;

    logic wr_ctrl;
    logic wr_prescale;
    logic wr_compare;
    logic wr_count;
    logic wr_status;

    logic                      en;
    logic                      auto_reload;
    logic                      irq_en;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic [PRESCALE_WIDTH-1:0] pcnt;
    logic [DATA_WIDTH-1:0]     compare;
    logic [DATA_WIDTH-1:0]     count;
    logic                      match;

    logic tick;
    logic hit;
    logic tick_live;

    logic unused_addr;

    assign idx = address[4:2];
    assign wr  = sel & we;

    // Only the word index is decoded; remaining address bits are ignored.
    assign unused_addr = ^{address[31:5], address[1:0]};

    assign is_ctrl     = (idx == IDX_CTRL);
    assign is_prescale = (idx == IDX_PRESCALE);
    assign is_compare  = (idx == IDX_COMPARE);
    assign is_count    = (idx == IDX_COUNT);
    assign is_status   = (idx == IDX_STATUS);

    assign wr_ctrl     = wr & is_ctrl;
    assign wr_prescale = wr & is_prescale;
    assign wr_compare  = wr & is_compare;
    assign wr_count    = wr & is_count;
    assign wr_status   = wr & is_status;

    // A tick fires when the prescaler reaches PRESCALE; a bus write to
    // COUNT on that cycle discards the whole tick, including any match.
    assign tick      = en && (pcnt == prescale);
    assign tick_live = tick && !wr_count;
    assign hit       = tick_live && (count == compare);

    assign irq = match & irq_en;

    // Prescaler: free-runs while enabled, restarts on tick or PRESCALE write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (wr_prescale) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else if (en) begin
            pcnt <= pcnt + PONE;
        end
    end

    // Control bits; a bus write overrides a one-shot disable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en          <= 1'b0;
            auto_reload <= 1'b0;
            irq_en      <= 1'b0;
        end else if (wr_ctrl) begin
            en          <= wd[0];
            auto_reload <= wd[1];
            irq_en      <= wd[2];
        end else if (hit && !auto_reload) begin
            en <= 1'b0;
        end
    end

    // Plain configuration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale <= '0;
            compare  <= COMPARE_RST;
        end else begin
            if (wr_prescale) begin
                prescale <= wd[PRESCALE_WIDTH-1:0];
            end
            if (wr_compare) begin
                compare <= wd;
            end
        end
    end

    // Up-counter: bus write wins, otherwise advance, reload or hold on tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (wr_count) begin
            count <= wd;
        end else if (tick_live) begin
            if (hit) begin
                if (auto_reload) begin
                    count <= '0;
                end
            end else begin
                count <= count + CONE;
            end
        end
    end

    // Sticky match flag; a new match beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match <= 1'b0;
        end else if (hit) begin
            match <= 1'b1;
        end else if (wr_status && wd[0]) begin
            match <= 1'b0;
        end
    end

    // Zero-wait-state read mux; unmapped words and idle bus read zero.
    always_comb begin
        rd = '0;
        if (sel) begin
            unique case (1'b1)
                is_ctrl: begin
                    rd = {{(DATA_WIDTH-3){1'b0}}, irq_en, auto_reload, en};
                end
                is_prescale: begin
                    rd = DATA_WIDTH'(prescale);
                end
                is_compare: begin
                    rd = compare;
                end
                is_count: begin
                    rd = count;
                end
                is_status: begin
                    rd = {{(DATA_WIDTH-1){1'b0}}, match};
                end
                default: begin
                    rd = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_timer_slave.sv
// tb_mmio_timer_slave: directed bench for mmio_timer_slave with an
// expected-value queue checked through immediate assertions.
`timescale 1ns/1ps
module tb_mmio_timer_slave;

    logic        clk;
    logic        rst_n;
    logic [31:0] wd;
    logic [31:0] address;
    logic        we;
    logic        sel;
    logic [31:0] rd;
    logic        irq;

    logic [31:0] exp_q[$];
    int          passed;
    int          total;

    mmio_timer_slave dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wd      (wd),
        .address (address),
        .we      (we),
        .sel     (sel),
        .rd      (rd),
        .irq     (irq)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        total++;
        if (exp_q.size() == 0) begin
            $error("FAIL %s: observed %h with no expected value queued", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) passed++;
            else $error("FAIL %s: observed %h expected %h", tag, obs, e);
        end
    endtask

    // Called in the low clock phase; consumes exactly one rising edge.
    task automatic bus_write(input logic [2:0] idx, input logic [31:0] data);
        sel     = 1'b1;
        we      = 1'b1;
        address = {27'd0, idx, 2'b00};
        wd      = data;
        @(negedge clk);
        sel = 1'b0;
        we  = 1'b0;
        wd  = '0;
    endtask

    // Combinational read; consumes no rising edge.
    task automatic read_chk(input logic [2:0] idx, input logic [31:0] e,
                            input string tag);
        exp_q.push_back(e);
        sel     = 1'b1;
        we      = 1'b0;
        address = {27'd0, idx, 2'b00};
        #1;
        chk(tag, rd);
        sel = 1'b0;
    endtask

    task automatic irq_chk(input logic e, input string tag);
        exp_q.push_back({31'd0, e});
        chk(tag, {31'd0, irq});
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        passed  = 0;
        total   = 0;
        rst_n   = 1'b0;
        sel     = 1'b0;
        we      = 1'b0;
        wd      = '0;
        address = '0;
        run(2);
        rst_n = 1'b1;

        // reset while running
        bus_write(3'd0, 32'd1);
        run(5);
        read_chk(3'd3, 32'd5, "running_count");
        #2 rst_n = 1'b0;
        read_chk(3'd3, 32'd0, "async_rst_count");
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(32'd0);
        #1;
        chk("rd_idle", rd);
        irq_chk(1'b0, "rst_irq");
        read_chk(3'd3, 32'd0, "rst_count");
        read_chk(3'd2, 32'hFFFF_FFFF, "rst_compare");
        read_chk(3'd0, 32'd0, "rst_ctrl");
        read_chk(3'd1, 32'd0, "rst_prescale");
        read_chk(3'd4, 32'd0, "rst_status");

        // prescale by 4
        run(1);
        bus_write(3'd1, 32'd3);
        bus_write(3'd2, 32'd100);
        bus_write(3'd0, 32'd1);
        run(40);
        read_chk(3'd3, 32'd10, "pre_count");
        read_chk(3'd4, 32'd0, "pre_status");
        bus_write(3'd0, 32'd0);

        // auto-reload
        bus_write(3'd1, 32'd0);
        bus_write(3'd3, 32'd0);
        bus_write(3'd2, 32'd5);
        bus_write(3'd0, 32'd7);
        run(5);
        read_chk(3'd3, 32'd5, "ar_count5");
        read_chk(3'd4, 32'd0, "ar_nomatch");
        irq_chk(1'b0, "ar_irq_low");
        run(1);
        read_chk(3'd4, 32'd1, "ar_match");
        irq_chk(1'b1, "ar_irq_high");
        read_chk(3'd3, 32'd0, "ar_reload");
        bus_write(3'd4, 32'd1);
        irq_chk(1'b0, "ar_irq_clr");
        read_chk(3'd4, 32'd0, "ar_status_clr");
        run(4);
        read_chk(3'd4, 32'd0, "ar2_nomatch");
        read_chk(3'd3, 32'd5, "ar2_count5");
        run(1);
        read_chk(3'd4, 32'd1, "ar2_match");
        read_chk(3'd3, 32'd0, "ar2_reload");

        // W1C colliding with a match
        bus_write(3'd4, 32'd1);
        read_chk(3'd4, 32'd0, "w1c_clear");
        run(4);
        read_chk(3'd3, 32'd5, "w1c_count5");
        bus_write(3'd4, 32'd1);
        read_chk(3'd4, 32'd1, "w1c_set_wins");
        read_chk(3'd3, 32'd0, "w1c_reload");

        // COUNT write colliding with a tick
        bus_write(3'd3, 32'h50);
        read_chk(3'd3, 32'h50, "cnt_wr_wins");
        bus_write(3'd0, 32'd0);
        run(3);
        read_chk(3'd3, 32'h51, "cnt_hold_dis");

        // one-shot
        bus_write(3'd4, 32'd1);
        bus_write(3'd3, 32'd0);
        bus_write(3'd2, 32'd2);
        bus_write(3'd0, 32'd1);
        run(2);
        read_chk(3'd4, 32'd0, "os_nomatch");
        read_chk(3'd3, 32'd2, "os_count2");
        run(1);
        read_chk(3'd4, 32'd1, "os_match");
        read_chk(3'd0, 32'd0, "os_ctrl_off");
        run(20);
        read_chk(3'd3, 32'd2, "os_hold");
        irq_chk(1'b0, "os_irq_masked");

        // one-shot disable colliding with CTRL write
        bus_write(3'd4, 32'd1);
        bus_write(3'd3, 32'd0);
        bus_write(3'd0, 32'd1);
        run(2);
        bus_write(3'd0, 32'd1);
        read_chk(3'd0, 32'd1, "os_ctrl_wins");
        read_chk(3'd4, 32'd1, "os_ctrl_match");
        bus_write(3'd0, 32'd0);

        // decode
        bus_write(3'd6, 32'hDEAD);
        read_chk(3'd6, 32'd0, "idx6_zero");
        bus_write(3'd0, 32'hFFFF_FFFF);
        read_chk(3'd0, 32'd7, "ctrl_mask");
        sel     = 1'b0;
        we      = 1'b1;
        address = 32'd0;
        wd      = 32'd0;
        @(negedge clk);
        we = 1'b0;
        read_chk(3'd0, 32'd7, "nosel_write");
        read_chk(3'd1, 32'd0, "idx6_no_alias");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
